seq_serializer: RTL

//  Parallel-to-serial front end for the serial pattern detectors.
//  - Accepts WIDTH-bit words on a valid/ready handshake.
//  - Emits one bit per clk on ser_out, which drives a detector's seq_in.
//  - Optional idle gap between words; optional trailing parity bit.

---
 rtl/seq_serializer_pkg.sv | 21 ++
 rtl/seq_serializer_shift_reg.sv | 66 ++++++
 rtl/seq_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared types and sizing helpers for the seq_serializer block.
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } ser_state_t;

   // Width of a counter that must hold 0..width without wrapping.
   function automatic int ser_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int SER_WIDTH_DEF = 8;
   localparam int SER_CNT_W     = ser_cnt_w(SER_WIDTH_DEF);
   // GAP_CYCLES tops out at 255, so an 8-bit gap counter always suffices.
   localparam int SER_GAP_W     = 8;

endpackage

// File: rtl/seq_serializer_shift_reg.sv
// Loadable shift register with a direction select, used by seq_serializer.
// out_bit is the head bit the register will present after the current edge,
// so the parent can register it straight into its serial output flop.
module ser_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             load_msb_first,
   input  logic [WIDTH-1:0] load_data,
   output logic             out_bit,
   output logic             parity
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] shl, shr;
   logic             msb_first_q, msb_first_d;
   logic             parity_q, parity_d;

   // Shift-left and shift-right views of the stored word.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lo
         assign shl[gi] = 1'b0;
         assign shr[gi] = data_q[gi+1];
      end else if (gi == WIDTH - 1) begin : g_hi
         assign shl[gi] = data_q[gi-1];
         assign shr[gi] = 1'b0;
      end else begin : g_mid
         assign shl[gi] = data_q[gi-1];
         assign shr[gi] = data_q[gi+1];
      end
   end

   // Next contents: load a fresh word or advance toward the next bit.
   always_comb begin
      data_d      = data_q;
      msb_first_d = msb_first_q;
      parity_d    = parity_q;
      if (load) begin
         data_d      = load_data;
         msb_first_d = load_msb_first;
         parity_d    = ^load_data;
      end else if (shift) begin
         data_d = msb_first_q ? shl : shr;
      end
   end

   // Register state; parity is captured at load since the data is consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         msb_first_q <= 1'b0;
         parity_q    <= 1'b0;
      end else begin
         data_q      <= data_d;
         msb_first_q <= msb_first_d;
         parity_q    <= parity_d;
      end
   end

   assign out_bit = msb_first_d ? data_d[WIDTH-1] : data_d[0];
   assign parity  = parity_q;

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the serial pattern detectors.
// Optional trailing even-parity bit is enabled by defining SER_PARITY_EN.
module seq_serializer
   import ser_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             msb_first,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy,
   output logic             word_done
);

   localparam int                   CNT_W    = ser_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(WIDTH - 1);
   localparam logic [SER_GAP_W-1:0] GAP_LAST =
      SER_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit                   B2B_EN   = (GAP_CYCLES == 0);
`ifdef SER_PARITY_EN
   localparam bit                   PARITY_EN = 1'b1;
`else
   localparam bit                   PARITY_EN = 1'b0;
`endif

   ser_state_t           state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [SER_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic                 ser_out_q, ser_out_d;
   logic                 ser_valid_q, ser_valid_d;
   logic                 word_done_q, word_done_d;
   logic                 busy_q, busy_d;

   logic sr_load, sr_shift, sr_out_bit, sr_parity;
   logic accept, last_bit, start_word, end_word;

   ser_shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk            (clk),
      .rst            (rst),
      .load           (sr_load),
      .shift          (sr_shift),
      .load_msb_first (msb_first),
      .load_data      (din),
      .out_bit        (sr_out_bit),
      .parity         (sr_parity)
   );

   assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);

   // Ready in IDLE, and on the final line bit of a word when no gap follows.
   always_comb begin
      din_ready = 1'b0;
      if (!rst) begin
         if (state_q == IDLE) begin
            din_ready = 1'b1;
         end else if (B2B_EN) begin
            din_ready = PARITY_EN ? (state_q == PARITY) : last_bit;
         end
      end
   end

   assign accept = din_valid & din_ready;

   // Next-state, counter and output-register values.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ser_out_d   = IDLE_LEVEL;
      ser_valid_d = 1'b0;
      word_done_d = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      start_word  = 1'b0;
      end_word    = 1'b0;

      case (state_q)
         IDLE: begin
            start_word = accept;
         end
         SHIFT: begin
            if (!last_bit) begin
               sr_shift    = 1'b1;
               bit_cnt_d   = bit_cnt_q + CNT_W'(1);
               ser_out_d   = sr_out_bit;
               ser_valid_d = 1'b1;
               word_done_d = !PARITY_EN && ((bit_cnt_q + CNT_W'(1)) == LAST_IDX);
            end else if (PARITY_EN) begin
               state_d     = PARITY;
               ser_out_d   = sr_parity;
               ser_valid_d = 1'b1;
               word_done_d = 1'b1;
            end else begin
               end_word = 1'b1;
            end
         end
         PARITY: begin
            end_word = 1'b1;
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + SER_GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Leaving a word: idle gap, straight into the next word, or IDLE.
      if (end_word) begin
         if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
         end else if (accept) begin
            start_word = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end

      // First bit of a new word goes on the line the cycle after accept.
      if (start_word) begin
         state_d     = SHIFT;
         sr_load     = 1'b1;
         bit_cnt_d   = '0;
         ser_out_d   = sr_out_bit;
         ser_valid_d = 1'b1;
         word_done_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset aborts any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         ser_out_q   <= IDLE_LEVEL;
         ser_valid_q <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
      end
   end

   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign word_done = word_done_q;
   assign busy      = busy_q;

endmodule
